// File: rtl/lvds_rx_if.sv
// ---------------------------------------------------------------------------
// lvds_rx_if : bundle of the LVDS receiver data-path signals.
//
//   i_ddr_data     [1:0]  de-serialised DDR pair, bit[1] earlier on the wire
//   i_fifo_full           downstream FIFO cannot accept a write this cycle
//   o_fifo_write          one-cycle write strobe for o_fifo_data
//   o_fifo_data    [31:0] {sign-extended I, sign-extended Q}
//   o_locked              receiver is locked to the frame structure
//   o_phase               selected bit alignment (0 even, 1 odd)
//   o_overflow_cnt [15:0] saturating count of data frames dropped on full
//   o_frame_err           pulse on each malformed frame seen while locked
//
// master : the side that drives the serial pairs and FIFO status
// slave  : the receiver itself
// ---------------------------------------------------------------------------
interface lvds_rx_if;
    logic [1:0]  i_ddr_data;
    logic        i_fifo_full;
    logic        o_fifo_write;
    logic [31:0] o_fifo_data;
    logic        o_locked;
    logic        o_phase;
    logic [15:0] o_overflow_cnt;
    logic        o_frame_err;

    modport master (
        output i_ddr_data, i_fifo_full,
        input  o_fifo_write, o_fifo_data, o_locked, o_phase,
               o_overflow_cnt, o_frame_err
    );

    modport slave (
        input  i_ddr_data, i_fifo_full,
        output o_fifo_write, o_fifo_data, o_locked, o_phase,
               o_overflow_cnt, o_frame_err
    );
endinterface

// File: rtl/lvds_rx.sv
// ---------------------------------------------------------------------------
// lvds_rx : frame aligner / de-framer for a 2-bit-per-cycle LVDS stream.
//
// Frame (32 bits, MSB first):
//   [31:30]=2'b10, [29:17]=I, [16]=type, [15:14]=2'b01, [13:1]=Q, [0]=0
//
// Ports:
//   i_ddr_clk   sample clock, all logic on the rising edge
//   i_reset_n   asynchronous active-low reset
//   bus         lvds_rx_if.slave (pairs in, FIFO write/status and lock out)
//
// Parameters:
//   LOCK_FRAMES consecutive good frames needed to declare lock
//   LOSS_FRAMES consecutive bad frames in lock that drop back to hunting
// ---------------------------------------------------------------------------
module lvds_rx #(
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 2
) (
    input logic       i_ddr_clk,
    input logic       i_reset_n,
    lvds_rx_if.slave  bus
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [7:0] LOSS_N = 8'(LOSS_FRAMES);

    // Only 33 history bits are ever observed (odd candidate reaches bit 32),
    // so the oldest bit of the 34-bit history is not stored.
    logic [32:0]        hist_p0;
    logic [1:0]         state;
    logic [3:0]         pair_cnt;
    logic [7:0]         good_cnt;
    logic [7:0]         bad_cnt;
    logic               phase;
    logic               vld_p1;
    logic [31:0]        data_p1;
    logic [15:0]        ovf_cnt;
    logic               err_p1;

    logic [31:0]        cand_even;
    logic [31:0]        cand_odd;
    logic [31:0]        cand_sel;
    logic               even_ok;
    logic               odd_ok;
    logic               sel_ok;
    logic               boundary;

    function automatic logic well_formed(input logic [1:0] head,
                                         input logic [1:0] mid,
                                         input logic       tail);
        return (head == 2'b10) && (mid == 2'b01) && !tail;
    endfunction

    function automatic logic signed [15:0] sext13(input logic signed [12:0] v);
        return 16'(v);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cand_even = hist_p0[31:0];
    assign cand_odd  = hist_p0[32:1];
    assign cand_sel  = phase ? cand_odd : cand_even;
    assign even_ok   = well_formed(cand_even[31:30], cand_even[15:14], cand_even[0]);
    assign odd_ok    = well_formed(cand_odd[31:30], cand_odd[15:14], cand_odd[0]);
    assign sel_ok    = well_formed(cand_sel[31:30], cand_sel[15:14], cand_sel[0]);
    // pair_cnt is cleared on the edge that found the first frame, so the
    // next complete frame sits in the history when the counter reads 15.
    assign boundary  = (pair_cnt == 4'd15);

    // ---- stage p0 -> p1: history shift, alignment FSM, FIFO write ----
    always_ff @(posedge i_ddr_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist_p0  <= '0;
            state    <= HUNT;
            pair_cnt <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            phase    <= 1'b0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            ovf_cnt  <= '0;
            err_p1   <= 1'b0;
        end else begin
            hist_p0 <= {hist_p0[31:0], bus.i_ddr_data};
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            case (state)
                HUNT: begin
                    if (even_ok || odd_ok) begin
                        phase    <= ~even_ok;   // even wins a tie
                        state    <= CHECK;
                        good_cnt <= 8'd1;
                        pair_cnt <= '0;
                    end
                end
                CHECK: begin
                    pair_cnt <= pair_cnt + 4'd1;
                    if (boundary) begin
                        if (sel_ok) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt + 8'd1 == LOCK_N) begin
                                state   <= LOCKED;
                                bad_cnt <= '0;
                            end
                        end else begin
                            state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    pair_cnt <= pair_cnt + 4'd1;
                    if (boundary) begin
                        if (sel_ok) begin
                            bad_cnt <= '0;
                            if (cand_sel[16]) begin
                                if (!bus.i_fifo_full) begin
                                    vld_p1  <= 1'b1;
                                    data_p1 <= {sext13(cand_sel[29:17]),
                                                sext13(cand_sel[13:1])};
                                end else begin
                                    ovf_cnt <= sat_inc16(ovf_cnt);
                                end
                            end
                        end else begin
                            err_p1  <= 1'b1;
                            bad_cnt <= bad_cnt + 8'd1;
                            if (bad_cnt + 8'd1 == LOSS_N) begin
                                state <= HUNT;
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign bus.o_fifo_write   = vld_p1;
    assign bus.o_fifo_data    = data_p1;
    assign bus.o_locked       = (state == LOCKED);
    assign bus.o_phase        = phase;
    assign bus.o_overflow_cnt = ovf_cnt;
    assign bus.o_frame_err    = err_p1;

endmodule

// File: tb/tb_lvds_rx.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx : self-checking bench for lvds_rx. A bit-level stream of frames
// is fed two bits per cycle; a frame-level reference model predicts every
// output each cycle, and directed scenarios add absolute checks.
// ---------------------------------------------------------------------------
module tb_lvds_rx;
    localparam int LOCK_FRAMES = 4;
    localparam int LOSS_FRAMES = 2;
    localparam logic [31:0] IDLE = 32'h80004000;
    localparam logic [31:0] DATA = 32'hBFFF4002;  // I=1FFF, Q=0001, type=1
    localparam logic [31:0] BAD  = 32'hFFFF4002;  // header corrupted to 2'b11

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lvds_rx_if bus();

    lvds_rx #(.LOCK_FRAMES(LOCK_FRAMES), .LOSS_FRAMES(LOSS_FRAMES)) dut (
        .i_ddr_clk (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // stimulus state
    bit   bitq[$];
    logic rst_drv  = 1'b0;
    logic full_drv = 1'b0;
    bit   rand_full = 1'b0;

    // bookkeeping
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_seen = 0;
    int          err_seen = 0;
    logic [31:0] last_data = '0;

    // reference model
    typedef enum {M_HUNT, M_CHECK, M_LOCKED} mstate_t;
    mstate_t     m_st;
    logic [33:0] m_hist;
    int          m_since, m_good, m_bad;
    logic        m_phase, m_write, m_err;
    logic [31:0] m_data;
    logic [15:0] m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit frame_ok(input logic [31:0] f);
        return f[31:30] == 2'b10 && f[15:14] == 2'b01 && f[0] == 1'b0;
    endfunction

    function automatic logic [31:0] mk_frame(input logic [12:0] i, input logic [12:0] q,
                                             input logic typ);
        return {2'b10, i, typ, 2'b01, q, 1'b0};
    endfunction

    task automatic model_reset();
        m_st = M_HUNT; m_hist = '0; m_since = 0; m_good = 0; m_bad = 0;
        m_phase = 1'b0; m_write = 1'b0; m_err = 1'b0; m_data = '0; m_ovf = '0;
    endtask

    task automatic model_step(input logic [1:0] d, input logic full);
        logic [31:0] ev, od, sel;
        int iv, qv;
        ev = m_hist[31:0];
        od = m_hist[32:1];
        m_write = 1'b0;
        m_err = 1'b0;
        if (m_st == M_HUNT) begin
            if (frame_ok(ev) || frame_ok(od)) begin
                m_phase = frame_ok(ev) ? 1'b0 : 1'b1;
                m_st = M_CHECK;
                m_good = 1;
                m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since == 16) begin
                m_since = 0;
                sel = m_phase ? od : ev;
                if (m_st == M_CHECK) begin
                    if (frame_ok(sel)) begin
                        m_good++;
                        if (m_good == LOCK_FRAMES) begin
                            m_st = M_LOCKED;
                            m_bad = 0;
                        end
                    end else begin
                        m_st = M_HUNT;
                    end
                end else if (frame_ok(sel)) begin
                    m_bad = 0;
                    if (sel[16]) begin
                        if (!full) begin
                            iv = $signed(sel[29:17]);
                            qv = $signed(sel[13:1]);
                            m_write = 1'b1;
                            m_data = {iv[15:0], qv[15:0]};
                        end else if (m_ovf != 16'hFFFF) begin
                            m_ovf = m_ovf + 16'd1;
                        end
                    end
                end else begin
                    m_bad++;
                    m_err = 1'b1;
                    if (m_bad == LOSS_FRAMES) m_st = M_HUNT;
                end
            end
        end
        m_hist = {m_hist[31:0], d};
    endtask

    task automatic compare_all();
        check("write",    {31'd0, bus.o_fifo_write}, {31'd0, m_write});
        check("data",     bus.o_fifo_data, m_data);
        check("locked",   {31'd0, bus.o_locked}, {31'd0, m_st == M_LOCKED});
        check("phase",    {31'd0, bus.o_phase}, {31'd0, m_phase});
        check("overflow", {16'd0, bus.o_overflow_cnt}, {16'd0, m_ovf});
        check("frame_err",{31'd0, bus.o_frame_err}, {31'd0, m_err});
        if (bus.o_fifo_write) begin
            wr_seen++;
            last_data = bus.o_fifo_data;
        end
        if (bus.o_frame_err) err_seen++;
    endtask

    task automatic push_frame(input logic [31:0] f);
        for (int i = 31; i >= 0; i--) bitq.push_back(f[i]);
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            logic [1:0] d;
            @(negedge clk);
            d = 2'b00;
            if (bitq.size() >= 2) begin
                d[1] = bitq.pop_front();
                d[0] = bitq.pop_front();
            end
            bus.i_ddr_data  = d;
            bus.i_fifo_full = rand_full ? ($urandom_range(0, 4) == 0) : full_drv;
            rst_n = rst_drv;
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(d, bus.i_fifo_full);
            #1 compare_all();
        end
    endtask

    task automatic send_frames(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) push_frame(f);
        run_cycles(16 * n);
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        run_cycles(2);
        bitq.delete();
        rst_drv = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0;
        logic [31:0] f;
        int pos[5];
        pos = '{31, 30, 15, 14, 0};
        bus.i_ddr_data = 2'b00;
        bus.i_fifo_full = 1'b0;
        model_reset();

        // reset state
        run_cycles(3);
        check("rst_locked", {31'd0, bus.o_locked}, 32'd0);
        check("rst_data", bus.o_fifo_data, 32'd0);
        check("rst_ovf", {16'd0, bus.o_overflow_cnt}, 32'd0);
        rst_drv = 1'b1;

        // even aligned: idles then data
        for (int i = 0; i < 6; i++) push_frame(IDLE);
        for (int i = 0; i < 4; i++) push_frame(DATA);
        push_frame(IDLE);
        run_cycles(64);
        check("lock_not_yet", {31'd0, bus.o_locked}, 32'd0);
        run_cycles(1);
        check("lock_after_4", {31'd0, bus.o_locked}, 32'd1);
        check("even_phase", {31'd0, bus.o_phase}, 32'd0);
        run_cycles(111);
        check("even_writes", wr_seen, 32'd4);
        check("even_data", last_data, 32'hFFFF0001);

        // same stream delayed by one bit
        do_reset();
        check("reset_unlock", {31'd0, bus.o_locked}, 32'd0);
        w0 = wr_seen;
        last_data = '0;
        bitq.push_back(1'b0);
        for (int i = 0; i < 6; i++) push_frame(IDLE);
        for (int i = 0; i < 4; i++) push_frame(DATA);
        push_frame(IDLE);
        run_cycles(176);
        check("odd_locked", {31'd0, bus.o_locked}, 32'd1);
        check("odd_phase", {31'd0, bus.o_phase}, 32'd1);
        check("odd_writes", wr_seen - w0, 32'd4);
        check("odd_data", last_data, 32'hFFFF0001);

        // FIFO full drops three data frames
        w0 = wr_seen;
        send_frames(IDLE, 1);
        full_drv = 1'b1;
        send_frames(DATA, 3);
        send_frames(IDLE, 1);
        full_drv = 1'b0;
        check("ovf_count", {16'd0, bus.o_overflow_cnt}, 32'd3);
        check("ovf_nowrite", wr_seen - w0, 32'd0);
        send_frames(DATA, 3);
        send_frames(IDLE, 1);
        check("ovf_resume", wr_seen - w0, 32'd3);
        check("ovf_hold", {16'd0, bus.o_overflow_cnt}, 32'd3);

        // single and double corrupted frames
        e0 = err_seen;
        send_frames(IDLE, 1);
        send_frames(BAD, 1);
        send_frames(IDLE, 2);
        check("err_single", err_seen - e0, 32'd1);
        check("err_keeplock", {31'd0, bus.o_locked}, 32'd1);
        send_frames(BAD, 2);
        send_frames(IDLE, 1);
        check("err_double", err_seen - e0, 32'd3);
        check("err_unlock", {31'd0, bus.o_locked}, 32'd0);

        // reset at pair 7 of a data frame
        do_reset();
        send_frames(IDLE, 5);
        check("pre_rst_lock", {31'd0, bus.o_locked}, 32'd1);
        w0 = wr_seen;
        push_frame(DATA);
        run_cycles(7);
        do_reset();
        check("midrst_nowrite", wr_seen - w0, 32'd0);
        check("midrst_data", bus.o_fifo_data, 32'd0);
        check("midrst_locked", {31'd0, bus.o_locked}, 32'd0);
        for (int i = 0; i < 5; i++) push_frame(IDLE);
        run_cycles(64);
        check("relock_not_yet", {31'd0, bus.o_locked}, 32'd0);
        run_cycles(1);
        check("relock", {31'd0, bus.o_locked}, 32'd1);
        run_cycles(15);
        send_frames(DATA, 1);
        send_frames(IDLE, 1);
        check("relock_write", wr_seen - w0, 32'd1);

        // idle only
        do_reset();
        w0 = wr_seen;
        send_frames(IDLE, 8);
        check("idle_locked", {31'd0, bus.o_locked}, 32'd1);
        check("idle_nowrite", wr_seen - w0, 32'd0);

        // randomized traffic with random FIFO back-pressure
        do_reset();
        if ($urandom_range(0, 1) == 1) bitq.push_back(1'b0);
        for (int i = 0; i < 4; i++) push_frame(IDLE);
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            f = mk_frame(13'($urandom), 13'($urandom), 1'b1);
            if (r >= 6 && r < 8) f = IDLE;
            else if (r >= 8) f[pos[$urandom_range(0, 4)]] ^= 1'b1;
            push_frame(f);
        end
        rand_full = 1'b1;
        run_cycles(bitq.size() / 2);
        rand_full = 1'b0;
        send_frames(IDLE, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lvds_rx.md
LVDS_RX -- requirements
Module: lvds_rx

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 4: consecutive well-formed frames required to enter LOCKED.
REQ-002 The block SHALL have parameter LOSS_FRAMES, default 2: consecutive malformed frames in LOCKED that force HUNT.
REQ-003 Port i_ddr_clk, input, 1: sample clock; all logic on rising edge; one 2-bit pair per edge.
REQ-004 Port i_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port i_ddr_data, input, 2: de-serialised DDR pair; bit[1] is the earlier (more significant) bit on the wire.
REQ-006 Port i_fifo_full, input, 1: downstream FIFO cannot accept a write this cycle.
REQ-007 Port o_fifo_write, output, 1: one-cycle write strobe for o_fifo_data.
REQ-008 Port o_fifo_data, output, 32: {sign-extended I[12:0] to 16, sign-extended Q[12:0] to 16}.
REQ-009 Port o_locked, output, 1: high only in LOCKED.
REQ-010 Port o_phase, output, 1: selected bit alignment; 0 = even, 1 = odd (one-bit slip).
REQ-011 Port o_overflow_cnt, output, 16: saturating count of data frames dropped because i_fifo_full was high.
REQ-012 Port o_frame_err, output, 1: one-cycle pulse on each malformed frame boundary in LOCKED.

Function
REQ-013 Frame SHALL be 32 bits, MSB first, 16 pairs: [31:30]=2'b10, [29:17]=I, [16]=type, [15:14]=2'b01, [13:1]=Q, [0]=0.
REQ-014 A frame SHALL be well-formed when [31:30]==2'b10, [15:14]==2'b01 and [0]==0; type=1 marks data, type=0 marks idle (idle frame is 32'h80004000).
REQ-015 History register h[33:0] SHALL shift by {h[31:0], i_ddr_data} every cycle; even candidate = h[31:0], odd candidate = h[32:1].
REQ-016 States SHALL be HUNT, CHECK, LOCKED.
REQ-017 HUNT: each cycle, if even candidate is well-formed, set phase=0; else if odd is well-formed, set phase=1 (even wins when both match); then go to CHECK with good count 1 and pair counter 0.
REQ-018 The pair counter (4 bits, wraps 15->0) SHALL define the frame boundary every 16 cycles after the boundary found in HUNT.
REQ-019 CHECK: at each boundary, a well-formed candidate of the selected phase increments good count; reaching LOCK_FRAMES goes to LOCKED; a malformed candidate returns to HUNT.
REQ-020 LOCKED: at each boundary, a well-formed candidate clears bad count; a malformed one increments it and pulses o_frame_err; reaching LOSS_FRAMES goes to HUNT, deasserts o_locked, and writes nothing.
REQ-021 In LOCKED, a well-formed data frame at a boundary SHALL assert o_fifo_write exactly one cycle, registered on the edge following the edge that captured the frame's last pair, when i_fifo_full is low at that boundary.
REQ-022 Idle frames, frames in HUNT/CHECK and malformed frames SHALL never cause o_fifo_write.
REQ-023 When a data frame is dropped for i_fifo_full, o_overflow_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-024 o_fifo_data SHALL update only with o_fifo_write and hold otherwise; I/Q sign extension copies bit 12 into bits 15:13.
REQ-025 Frames are not written during HUNT/CHECK, so the first write SHALL occur at the boundary after the LOCK_FRAMES-th good frame.

Reset
REQ-026 While i_reset_n is low: state HUNT, h=0, counters 0, o_fifo_write=0, o_fifo_data=0, o_locked=0, o_phase=0, o_overflow_cnt=0, o_frame_err=0.
REQ-027 Reset asserted mid-frame SHALL abort without a write; after release, lock acquisition restarts from HUNT.

Verification
REQ-028 Even-aligned idle frames then data I=13'h1FFF, Q=13'h0001 -> o_locked after 4 frames, o_phase=0, write data 32'hFFFF0001.
REQ-029 Same stream delayed by one bit -> o_phase=1, identical o_fifo_data values.
REQ-030 Locked; i_fifo_full high for 3 data frames -> no writes, o_overflow_cnt=3; writes resume when full drops.
REQ-031 Locked; one corrupted frame ([31:30]=2'b11) -> o_frame_err pulse, o_locked stays 1; two consecutive -> o_locked=0, state HUNT.
REQ-032 i_reset_n low at pair 7 of a data frame -> no write, all outputs 0; relock after 4 good frames.
REQ-033 Only idle frames 32'h80004000 -> lock achieved, zero writes.
